instruction_memory_responder: RTL and testbench
===============================================

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit instruction words stored.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request acceptance and response; legal range 0..15.
REQ-003 Port clk  input  1  single clock; all flops on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port freeze  input  1  stall; holds the wait counter.
REQ-006 Port req_valid  input  1  fetch request present.
REQ-007 Port req_ready  output  1  responder can accept a request.
REQ-008 Port req_addr  input  32  byte address of the instruction (program counter value).
REQ-009 Port resp_valid  output  1  response word valid.
REQ-010 Port resp_ready  input  1  consumer accepts the response.
REQ-011 Port resp_instruction  output  32  fetched instruction word.
REQ-012 Port resp_fault  output  1  address misaligned or out of range.
REQ-013 Port load_enable  input  1  write one word into instruction storage.
REQ-014 Port load_addr  input  clog2(DEPTH_WORDS)  word index for load.
REQ-015 Port load_data  input  32  word to store.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready SHALL equal (state == IDLE).
REQ-017 Handshake: request accepted on a rising edge with req_valid && req_ready; req_addr latched that edge.
REQ-018 Transition: IDLE->WAIT on accept when WAIT_CYCLES > 0; IDLE->RESP on accept when WAIT_CYCLES == 0.
REQ-019 WAIT: counter loads WAIT_CYCLES on accept and decrements each non-frozen cycle; WAIT->RESP on the edge where the counter goes 1->0.
REQ-020 freeze=1 in WAIT: counter and state hold; in IDLE: no request accepted (req_ready forced 0); in RESP: no effect on resp_valid or response data.
REQ-021 Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge when freeze stays 0.
REQ-022 Storage read occurs on the WAIT->RESP (or IDLE->RESP) edge; resp_instruction and resp_fault registered there and held stable throughout RESP.
REQ-023 Fault: req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS -> resp_fault=1, resp_instruction=32'h00000000 (NOP).
REQ-024 RESP->IDLE on resp_valid && resp_ready; resp_valid deasserts the next cycle; the next request is not accepted in that same cycle.
REQ-025 Load: on load_enable, storage[load_addr] <= load_data in any state; storage is not reset.
REQ-026 Load to the pending word index on the same edge as the read: the read SHALL return the new load_data (write-first).
REQ-027 Load during RESP SHALL NOT alter the held resp_instruction.
REQ-028 req_addr changes while not in IDLE are ignored.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, counter 0, resp_valid 0, resp_instruction 0, resp_fault 0, regardless of clk.
REQ-030 Reset mid-WAIT or mid-RESP abandons the transaction; no response is emitted after release.
REQ-031 First request is accepted on the first rising edge after reset returns to 1.

Structure
REQ-032 Package mips_fetch_pkg SHALL hold the FSM state enum typedef, the NOP constant 32'h00000000, and the instruction word width 32.
REQ-033 Storage SHALL be a sub-module instruction_rom_array (one synchronous write port, one read port, write-first); FSM and counter live in instruction_memory_responder.

Verification
REQ-034 Reset release, load word 3 = 32'h2008000A, request addr 0x0000000C, resp_ready=1 -> resp_valid high 3 cycles after accept, instruction 32'h2008000A, fault 0.
REQ-035 Request addr 0x0000000E -> fault 1, instruction 0; request addr 0x00000400 (DEPTH 256) -> fault 1, instruction 0.
REQ-036 resp_ready held 0 for 5 cycles in RESP, load same word with 32'hFFFFFFFF -> resp_valid and original data held stable; completes when resp_ready=1.
REQ-037 freeze=1 for 4 cycles mid-WAIT -> response delayed exactly 4 cycles; freeze in IDLE -> req_ready 0.
REQ-038 Load word 5 with 32'h8C090004 on the read edge of request 0x00000014 -> response 32'h8C090004.
REQ-039 reset=0 pulse mid-WAIT (asynchronous, between edges) -> outputs 0 immediately, no stale resp_valid after release; WAIT_CYCLES=0 build -> latency 1 cycle.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
package mips_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } fetch_state_t;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Misaligned byte address or word index beyond the populated storage.
   function automatic logic addr_fault(input logic [31:0] addr, input int depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
   endfunction

endpackage

// File: rtl/instruction_rom_array.sv
// Instruction word storage: one synchronous write port, one combinational
// read port; a write to the word being read is forwarded to the read data.
module instruction_rom_array
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = idx_width(DEPTH_WORDS)
) (
   input  logic               clk,
   input  logic               i_wr_en,
   input  logic [AW-1:0]      i_wr_addr,
   input  logic [INSTR_W-1:0] i_wr_data,
   input  logic [AW-1:0]      i_rd_addr,
   output logic [INSTR_W-1:0] o_rd_data
);

   logic [INSTR_W-1:0] r_mem [DEPTH_WORDS];
   logic               w_fwd;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign w_fwd     = i_wr_en && (i_wr_addr == i_rd_addr);
   assign o_rd_data = w_fwd ? i_wr_data : r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_memory_responder.sv
// Instruction fetch responder: accepts a PC, waits WAIT_CYCLES wait states,
// then presents the stored word (or a NOP with fault) until consumed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request (unless frozen)
// ST_WAIT | wait-state down-counter running; held while frozen
// ST_RESP | response registered and held until resp_ready
module instruction_memory_responder
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2,
   localparam int AW         = idx_width(DEPTH_WORDS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               freeze,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_addr,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [INSTR_W-1:0] resp_instruction,
   output logic               resp_fault,
   input  logic               load_enable,
   input  logic [AW-1:0]      load_addr,
   input  logic [INSTR_W-1:0] load_data
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   fetch_state_t       r_state;
   logic [3:0]         r_cnt;
   logic [31:0]        r_addr;
   logic               r_resp_valid;
   logic [INSTR_W-1:0] r_instr;
   logic               r_fault;

   logic               w_accept;
   logic [31:0]        w_sel_addr;
   logic               w_fault;
   logic [INSTR_W-1:0] w_rom_data;
   logic [INSTR_W-1:0] w_rd_instr;

   assign req_ready = (r_state == ST_IDLE) && !freeze;
   assign w_accept  = req_valid && req_ready;

   // With zero wait states the read happens on the accept edge itself,
   // so the live request address feeds the storage while idle.
   assign w_sel_addr = (r_state == ST_IDLE) ? req_addr : r_addr;
   assign w_fault    = addr_fault(w_sel_addr, DEPTH_WORDS);
   assign w_rd_instr = w_fault ? NOP : w_rom_data;

   instruction_rom_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_rom (
      .clk       (clk),
      .i_wr_en   (load_enable),
      .i_wr_addr (load_addr),
      .i_wr_data (load_data),
      .i_rd_addr (w_sel_addr[AW+1:2]),
      .o_rd_data (w_rom_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_addr       <= 32'd0;
         r_resp_valid <= 1'b0;
         r_instr      <= NOP;
         r_fault      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr <= req_addr;
                  if (WAIT_CYCLES == 0) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_instr      <= w_rd_instr;
                     r_fault      <= w_fault;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!freeze) begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt <= 4'd1) begin
                     r_cnt        <= 4'd0;
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_instr      <= w_rd_instr;
                     r_fault      <= w_fault;
                  end
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_resp_valid <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign resp_valid       = r_resp_valid;
   assign resp_instruction = r_instr;
   assign resp_fault       = r_fault;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: directed scenarios plus randomized
// fetches checked against an array model of instruction storage.
module tb_instruction_memory_responder;

   localparam int DEPTH = 256;
   localparam int WAITS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        freeze, req_valid, req_ready, resp_valid, resp_ready, resp_fault, load_enable;
   logic [31:0] req_addr, resp_instruction, load_data;
   logic [7:0]  load_addr;

   logic        z_freeze, z_req_valid, z_req_ready, z_resp_valid, z_resp_ready, z_resp_fault, z_load_enable;
   logic [31:0] z_req_addr, z_resp_instruction, z_load_data;
   logic [7:0]  z_load_addr;

   logic [31:0] mem_model [DEPTH];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   instruction_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
      .clk(clk), .reset(reset), .freeze(freeze), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_instruction(resp_instruction), .resp_fault(resp_fault),
      .load_enable(load_enable), .load_addr(load_addr), .load_data(load_data));

   instruction_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .freeze(z_freeze), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_addr(z_req_addr), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_instruction(z_resp_instruction), .resp_fault(z_resp_fault),
      .load_enable(z_load_enable), .load_addr(z_load_addr), .load_data(z_load_data));

   function automatic logic exp_fault(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      return exp_fault(a) ? 32'h0 : mem_model[a / 4];
   endfunction

   task automatic load_word(input int idx, input logic [31:0] val);
      load_enable = 1'b1; load_addr = 8'(idx); load_data = val;
      mem_model[idx] = val;
      @(posedge clk); #1;
      load_enable = 1'b0;
   endtask

   // Issues one request and runs until resp_valid appears; lat counts the accept edge as 1.
   task automatic fetch(input logic [31:0] addr, input int fz_at, input int fz_len,
                        input int ld_at, input int ld_idx, input logic [31:0] ld_val,
                        output int lat, output logic [31:0] ins, output logic flt, output bit tmo);
      int n;
      req_valid = 1'b1; req_addr = addr;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom;
      n = 1; tmo = 1'b0;
      while (!resp_valid) begin
         if (n == fz_at) freeze = 1'b1;
         if (n == fz_at + fz_len) freeze = 1'b0;
         if (n == ld_at) begin
            load_enable = 1'b1; load_addr = 8'(ld_idx); load_data = ld_val;
            mem_model[ld_idx] = ld_val;
         end else begin
            load_enable = 1'b0;
         end
         if (n > 60) begin tmo = 1'b1; break; end
         @(posedge clk); #1; n++;
      end
      load_enable = 1'b0; freeze = 1'b0;
      lat = n; ins = resp_instruction; flt = resp_fault;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", resp_valid); end
      n_checks++; if (resp_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", resp_instruction); end
      n_checks++; if (resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", resp_fault); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", req_ready); end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_basic_fetch();
      int lat; logic [31:0] ins; logic flt; bit tmo;
      load_word(3, 32'h2008000A);
      resp_ready = 1'b1;
      fetch(32'h0000000C, -1, 0, -1, 0, 0, lat, ins, flt, tmo);
      n_checks++; if (tmo || lat != WAITS + 1) begin n_fail++; $display("FAIL basic_latency got %0d (timeout %0b) want %0d", lat, tmo, WAITS + 1); end
      n_checks++; if (ins !== 32'h2008000A) begin n_fail++; $display("FAIL basic_instr got %h want 2008000a", ins); end
      n_checks++; if (flt !== 1'b0) begin n_fail++; $display("FAIL basic_fault got %0b want 0", flt); end
      req_valid = 1'b1; req_addr = 32'h0000000C;
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL complete_valid got %0b want 0", resp_valid); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL no_same_cycle_accept ready got %0b want 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL back_to_back_accept ready got %0b want 0", req_ready); end
      for (int i = 0; i < 8 && !resp_valid; i++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
   endtask

   task automatic test_preload();
      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      load_word(3, 32'h2008000A);
   endtask

   task automatic test_faults();
      logic [31:0] addrs [3];
      int lat; logic [31:0] ins; logic flt; bit tmo;
      addrs[0] = 32'h0000000E; addrs[1] = 32'h00000400; addrs[2] = 32'h000003FC;
      resp_ready = 1'b1;
      foreach (addrs[k]) begin
         fetch(addrs[k], -1, 0, -1, 0, 0, lat, ins, flt, tmo);
         n_checks++; if (tmo || flt !== exp_fault(addrs[k])) begin n_fail++; $display("FAIL fault_flag addr %h got %0b want %0b", addrs[k], flt, exp_fault(addrs[k])); end
         n_checks++; if (ins !== exp_instr(addrs[k])) begin n_fail++; $display("FAIL fault_instr addr %h got %h want %h", addrs[k], ins, exp_instr(addrs[k])); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] ins; logic flt; bit tmo; logic [31:0] orig;
      load_word(7, 32'h13572468);
      orig = 32'h13572468;
      resp_ready = 1'b0;
      fetch(32'h0000001C, -1, 0, -1, 0, 0, lat, ins, flt, tmo);
      n_checks++; if (tmo || ins !== orig) begin n_fail++; $display("FAIL bp_first got %h want %h", ins, orig); end
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin load_enable = 1'b1; load_addr = 8'd7; load_data = 32'hFFFFFFFF; mem_model[7] = 32'hFFFFFFFF; end
         @(posedge clk); #1;
         load_enable = 1'b0;
         n_checks++; if (resp_valid !== 1'b1 || resp_instruction !== orig) begin n_fail++; $display("FAIL bp_hold cycle %0d valid %0b instr %h want 1 %h", i, resp_valid, resp_instruction, orig); end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %0b want 0", resp_valid); end
      fetch(32'h0000001C, -1, 0, -1, 0, 0, lat, ins, flt, tmo);
      n_checks++; if (tmo || ins !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bp_reload got %h want ffffffff", ins); end
      @(posedge clk); #1;
   endtask

   task automatic test_freeze();
      int lat; logic [31:0] ins; logic flt; bit tmo;
      resp_ready = 1'b1;
      fetch(32'h0000000C, 1, 4, -1, 0, 0, lat, ins, flt, tmo);
      n_checks++; if (tmo || lat != WAITS + 1 + 4) begin n_fail++; $display("FAIL freeze_wait_latency got %0d want %0d", lat, WAITS + 5); end
      n_checks++; if (ins !== 32'h2008000A) begin n_fail++; $display("FAIL freeze_wait_instr got %h want 2008000a", ins); end
      @(posedge clk); #1;
      freeze = 1'b1; req_valid = 1'b1; req_addr = 32'h0000000C;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_idle_ready got %0b want 0", req_ready); end
         @(posedge clk); #1;
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_idle_valid got %0b want 0", resp_valid); end
      end
      freeze = 1'b0; req_valid = 1'b0; #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL unfreeze_ready got %0b want 1", req_ready); end
   endtask

   task automatic test_write_first();
      int lat; logic [31:0] ins; logic flt; bit tmo;
      load_word(5, 32'h11111111);
      resp_ready = 1'b1;
      fetch(32'h00000014, -1, 0, WAITS, 5, 32'h8C090004, lat, ins, flt, tmo);
      n_checks++; if (tmo || ins !== 32'h8C090004) begin n_fail++; $display("FAIL write_first got %h want 8c090004", ins); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      int n;
      resp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h00000014;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #3 reset = 1'b0;
      #1;
      n_checks++; if (resp_valid !== 1'b0 || resp_instruction !== 32'h0 || resp_fault !== 1'b0) begin n_fail++; $display("FAIL async_reset outputs valid %0b instr %h fault %0b want 0 0 0", resp_valid, resp_instruction, resp_fault); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready got %0b want 1", req_ready); end
      #1 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL stale_resp cycle %0d got %0b want 0", i, resp_valid); end
      end
      #3 reset = 1'b0;
      req_valid = 1'b1; req_addr = 32'h00000014;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL first_edge_accept ready got %0b want 0", req_ready); end
      n = 1;
      while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
      n_checks++; if (n != WAITS + 1 || resp_instruction !== 32'h8C090004) begin n_fail++; $display("FAIL post_reset_fetch lat %0d instr %h want %0d 8c090004", n, resp_instruction, WAITS + 1); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, fz_at, fz_len, d; logic [31:0] ins, a; logic flt; bit tmo;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            load_word($urandom_range(0, DEPTH - 1), $urandom);
            continue;
         end
         case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            2: a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            default: begin a = $urandom; if (a < 32'(DEPTH * 4)) a = a + 32'(DEPTH * 4); end
         endcase
         fz_len = $urandom_range(0, 3);
         fz_at = (fz_len == 0) ? -1 : $urandom_range(1, WAITS);
         d = $urandom_range(0, 3);
         resp_ready = (d == 0);
         fetch(a, fz_at, fz_len, -1, 0, 0, lat, ins, flt, tmo);
         n_checks++; if (tmo || lat != WAITS + 1 + fz_len) begin n_fail++; $display("FAIL rand_latency addr %h got %0d want %0d", a, lat, WAITS + 1 + fz_len); end
         n_checks++; if (ins !== exp_instr(a) || flt !== exp_fault(a)) begin n_fail++; $display("FAIL rand_data addr %h got %h/%0b want %h/%0b", a, ins, flt, exp_instr(a), exp_fault(a)); end
         for (int i = 0; i < d; i++) begin
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b1 || resp_instruction !== exp_instr(a)) begin n_fail++; $display("FAIL rand_hold addr %h valid %0b instr %h", a, resp_valid, resp_instruction); end
         end
         resp_ready = 1'b1;
         @(posedge clk); #1;
         n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_complete got %0b want 0", resp_valid); end
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_v [2];
      z_load_enable = 1'b1; z_load_addr = 8'd2; z_load_data = 32'hCAFE0002;
      @(posedge clk); #1;
      z_load_enable = 1'b0;
      z_resp_ready = 1'b1; z_req_valid = 1'b1; z_req_addr = 32'h00000008;
      @(posedge clk); #1;
      n_checks++; if (z_resp_valid !== 1'b1 || z_resp_instruction !== 32'hCAFE0002) begin n_fail++; $display("FAIL zero_wait_latency valid %0b instr %h want 1 cafe0002", z_resp_valid, z_resp_instruction); end
      exp_v[0] = 0; exp_v[1] = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++; if (z_resp_valid !== exp_v[i % 2][0]) begin n_fail++; $display("FAIL zero_wait_alternate cycle %0d got %0b want %0b", i, z_resp_valid, exp_v[i % 2][0]); end
      end
      z_req_valid = 1'b0;
      @(posedge clk); #1;
      z_req_valid = 1'b1; z_req_addr = 32'h00000008;
      z_load_enable = 1'b1; z_load_addr = 8'd2; z_load_data = 32'h0BADF00D;
      @(posedge clk); #1;
      z_req_valid = 1'b0; z_load_enable = 1'b0;
      n_checks++; if (z_resp_instruction !== 32'h0BADF00D) begin n_fail++; $display("FAIL zero_wait_write_first got %h want 0badf00d", z_resp_instruction); end
      @(posedge clk); #1;
      z_req_valid = 1'b1; z_req_addr = 32'h00000401;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      n_checks++; if (z_resp_fault !== 1'b1 || z_resp_instruction !== 32'h0) begin n_fail++; $display("FAIL zero_wait_fault got %0b/%h want 1/0", z_resp_fault, z_resp_instruction); end
      @(posedge clk); #1;
   endtask

   initial begin
      freeze = 0; req_valid = 0; req_addr = 0; resp_ready = 0; load_enable = 0; load_addr = 0; load_data = 0;
      z_freeze = 0; z_req_valid = 0; z_req_addr = 0; z_resp_ready = 0; z_load_enable = 0; z_load_addr = 0; z_load_data = 0;
      test_reset();
      test_basic_fetch();
      test_preload();
      test_faults();
      test_backpressure();
      test_freeze();
      test_write_first();
      test_async_reset();
      test_random();
      test_zero_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
